sem_mem_fifo_connector: RTL and testbench
=========================================

# sem_mem_fifo_connector

Parametrised successor of the single-bit semaphore mailbox. It carries WIDTH-bit words from semaphore A (producer) to semaphore B (consumer) through a DEPTH-entry first-in-first-out buffer, instead of a single 1-bit slot. It adds occupancy reporting, a sticky overflow flag and a synchronous flush. It sits between the A and B semaphore cores in the clk_s domain. With WIDTH=1 and DEPTH=1 it is a drop-in replacement for the original mailbox.

## Interface
Parameters:
- WIDTH, 1, data word width in bits (≥1)
- DEPTH, 4, number of buffer entries (≥1; need not be a power of two)
- CW, $clog2(DEPTH+1), derived width of the occupancy count

Ports:
- clk_s  input  1  single clock; all state updates on the rising edge
- rstn_s  input  1  reset; asynchronous assert, active-low
- sema_write_o_s_A  input  1  producer write strobe
- sema_data_o_s_A  input  WIDTH  producer data
- sema_is_empty_i_s_A  output  1  buffer has at least one free entry (count < DEPTH)
- sema_valid_i_s_B  output  1  head word available (count != 0)
- sema_data_i_s_B  output  WIDTH  head word; 0 when sema_valid_i_s_B=0
- sema_ready_o_s_B  input  1  consumer accept; a pop occurs when valid & ready
- sema_flush  input  1  synchronous clear of buffer contents and overflow flag
- sema_count  output  CW  current occupancy, 0..DEPTH
- sema_overflow  output  1  sticky; set by a write attempted while full

## Operation
- State: storage array mem[DEPTH], write pointer wr_ptr, read pointer rd_ptr, count, overflow flag.
- Pointers run 0..DEPTH-1 and wrap explicitly to 0 after DEPTH-1. Modulo-2^n wrap is forbidden when DEPTH is not a power of two.
- Push: when sema_write_o_s_A=1 and count<DEPTH, the block stores the data at mem[wr_ptr] and advances wr_ptr.
  - Fullness is judged on the registered count only. A same-cycle pop does not make room for the push.
- Dropped write: when sema_write_o_s_A=1 and count==DEPTH, the data is discarded, all state is unchanged, and sema_overflow is set to 1.
- Pop: when sema_valid_i_s_B=1 and sema_ready_o_s_B=1, rd_ptr advances.
  - A ready asserted while empty has no effect.
- Simultaneous push and pop with 0<count<DEPTH: both pointers advance and count is unchanged.
- Count update: count increments on push only and decrements on pop only.
- Head output: sema_data_i_s_B = mem[rd_ptr], combinational from the registered pointer (show-ahead), gated to 0 when count==0.
- Flush: sema_flush=1 zeroes wr_ptr, rd_ptr, count and overflow at the next edge.
  - Flush has priority over a push or pop in the same cycle; that push is lost and does not set overflow.
- Overflow clears only on flush or reset.
- Reset (rstn_s=0, at any time, including mid-transfer): pointers, count and overflow go to 0 immediately.
  - mem is not reset; its contents are don't-care and are masked from the output.

## Timing
- Reset values: sema_is_empty_i_s_A=1, sema_valid_i_s_B=0, sema_data_i_s_B=0, sema_count=0, sema_overflow=0.
- Write-to-valid latency: a push at edge n makes valid=1 with the word on the data output after edge n (one cycle), matching the original mailbox.
- Pop-to-next-head latency: the next head word appears immediately after the popping edge.
- Derived outputs: sema_is_empty_i_s_A, sema_valid_i_s_B and sema_count derive from registers only.
  - No combinational path exists from any input to them.
  - The only input-to-output paths are none. sema_data_i_s_B depends only on registered state.
- Back-to-back operation: one push and one pop per cycle are sustainable indefinitely at 0<count<DEPTH.
- Release after reset: deassertion of rstn_s is synchronised externally. The first push is accepted on the first edge with rstn_s=1.

## Test plan
- Reset: after rstn_s low then high, outputs are is_empty=1, valid=0, data=0, count=0, overflow=0. With WIDTH=8, DEPTH=4, push 0xA5 -> next cycle valid=1, data=0xA5, count=1.
- Fill and drain: push 0x01..0x04 with ready=0 -> count=4, is_empty=0. Then hold ready=1 -> data 0x01,0x02,0x03,0x04 on consecutive cycles, valid=0 after the fourth pop.
- Overflow while full: with count=4, write 0xFF with ready=1 in the same cycle -> 0xFF is dropped, overflow=1, count=3. The drained sequence does not contain 0xFF. Overflow stays 1 until sema_flush is pulsed, then reads 0.
- Wrap-around with DEPTH=3: 10 continuous push+pop cycles of incrementing data at count=1 -> output order is preserved across pointer wrap and count stays 1.
- Flush vs push: flush=1 and write=1 in the same cycle at count=2 -> next cycle count=0, valid=0, overflow=0.
- Async reset mid-stream: assert rstn_s between edges at count=3 -> valid=0, count=0 and is_empty=1 with no clock edge. DEPTH=1, WIDTH=1 regression reproduces the original single-slot handshake.

Source files
------------

// File: rtl/sem_mem_fifo_connector.sv
// sem_mem_fifo_connector: WIDTH-bit, DEPTH-entry FIFO mailbox from semaphore A to semaphore B
// with occupancy count, sticky overflow flag and synchronous flush.
module sem_mem_fifo_connector #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_s,
    input  logic             rstn_s,
    input  logic             sema_write_o_s_A,
    input  logic [WIDTH-1:0] sema_data_o_s_A,
    output logic             sema_is_empty_i_s_A,
    output logic             sema_valid_i_s_B,
    output logic [WIDTH-1:0] sema_data_i_s_B,
    input  logic             sema_ready_o_s_B,
    input  logic             sema_flush,
    output logic [CW-1:0]    sema_count,
    output logic             sema_overflow
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             full, push, pop;

    // Explicit wrap keeps non-power-of-two depths inside the array.
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Fullness uses the registered count only, so a same-cycle pop never frees room for a push.
    always_comb begin
        full = count == CW'(DEPTH);
        push = sema_write_o_s_A & ~full & ~sema_flush;
        pop  = sema_ready_o_s_B & (count != '0) & ~sema_flush;
    end

    always_ff @(posedge clk_s or negedge rstn_s) begin
        if (!rstn_s) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (sema_flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop) rd_ptr <= nxt(rd_ptr);
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (sema_write_o_s_A && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_s) begin
        if (push) mem[wr_ptr] <= sema_data_o_s_A;
    end

    always_comb begin
        sema_is_empty_i_s_A = ~full;
        sema_valid_i_s_B    = count != '0;
        sema_data_i_s_B     = (count != '0) ? mem[rd_ptr] : '0;
        sema_count          = count;
        sema_overflow       = overflow;
    end
endmodule

// File: tb/tb_sem_mem_fifo_connector.sv
// tb_sem_mem_fifo_connector: directed vector bench for DEPTH=4/WIDTH=8, plus DEPTH=3 wrap
// and DEPTH=1/WIDTH=1 single-slot instances.
module tb_sem_mem_fifo_connector;
    logic clk_s = 1'b0;
    logic rstn_s = 1'b0;
    always #5 clk_s = ~clk_s;

    logic       w4, r4, f4, e4, v4, o4;
    logic [7:0] d4, q4;
    logic [2:0] c4;
    logic       w3, r3, f3, e3, v3, o3;
    logic [7:0] d3, q3;
    logic [1:0] c3;
    logic       w1, r1, f1, e1, v1, o1;
    logic [0:0] d1, q1;
    logic [0:0] c1;

    sem_mem_fifo_connector #(.WIDTH(8), .DEPTH(4)) dut (
        .clk_s(clk_s), .rstn_s(rstn_s), .sema_write_o_s_A(w4), .sema_data_o_s_A(d4),
        .sema_is_empty_i_s_A(e4), .sema_valid_i_s_B(v4), .sema_data_i_s_B(q4),
        .sema_ready_o_s_B(r4), .sema_flush(f4), .sema_count(c4), .sema_overflow(o4));
    sem_mem_fifo_connector #(.WIDTH(8), .DEPTH(3)) dut3 (
        .clk_s(clk_s), .rstn_s(rstn_s), .sema_write_o_s_A(w3), .sema_data_o_s_A(d3),
        .sema_is_empty_i_s_A(e3), .sema_valid_i_s_B(v3), .sema_data_i_s_B(q3),
        .sema_ready_o_s_B(r3), .sema_flush(f3), .sema_count(c3), .sema_overflow(o3));
    sem_mem_fifo_connector #(.WIDTH(1), .DEPTH(1)) dut1 (
        .clk_s(clk_s), .rstn_s(rstn_s), .sema_write_o_s_A(w1), .sema_data_o_s_A(d1),
        .sema_is_empty_i_s_A(e1), .sema_valid_i_s_B(v1), .sema_data_i_s_B(q1),
        .sema_ready_o_s_B(r1), .sema_flush(f1), .sema_count(c1), .sema_overflow(o1));

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic       r;
        logic       f;
        logic       v;
        logic [7:0] q;
        logic [2:0] c;
        logic       e;
        logic       o;
    } vec_t;

    vec_t vt[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic v, input logic [7:0] q,
                        input logic [2:0] c, input logic e, input logic o);
        chk({tag, " valid"}, 32'(v4), 32'(v));
        chk({tag, " data"}, 32'(q4), 32'(q));
        chk({tag, " count"}, 32'(c4), 32'(c));
        chk({tag, " is_empty"}, 32'(e4), 32'(e));
        chk({tag, " overflow"}, 32'(o4), 32'(o));
    endtask

    task automatic step;
        @(posedge clk_s);
        #1;
    endtask

    initial begin
        {w4, d4, r4, f4, w3, d3, r3, f3, w1, d1, r1, f1} = '0;
        //             w  d      r  f  v  q      c  e  o
        vt.push_back('{1, 8'hA5, 0, 0, 1, 8'hA5, 1, 1, 0});
        vt.push_back('{0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 0});
        vt.push_back('{1, 8'h01, 0, 0, 1, 8'h01, 1, 1, 0});
        vt.push_back('{1, 8'h02, 0, 0, 1, 8'h01, 2, 1, 0});
        vt.push_back('{1, 8'h03, 0, 0, 1, 8'h01, 3, 1, 0});
        vt.push_back('{1, 8'h04, 0, 0, 1, 8'h01, 4, 0, 0});
        vt.push_back('{0, 8'h00, 0, 0, 1, 8'h01, 4, 0, 0});
        vt.push_back('{1, 8'hFF, 1, 0, 1, 8'h02, 3, 1, 1});
        vt.push_back('{0, 8'h00, 1, 0, 1, 8'h03, 2, 1, 1});
        vt.push_back('{0, 8'h00, 1, 0, 1, 8'h04, 1, 1, 1});
        vt.push_back('{0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 1});
        vt.push_back('{0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 1});
        vt.push_back('{0, 8'h00, 0, 1, 0, 8'h00, 0, 1, 0});
        vt.push_back('{1, 8'h21, 0, 0, 1, 8'h21, 1, 1, 0});
        vt.push_back('{1, 8'h22, 0, 0, 1, 8'h21, 2, 1, 0});
        vt.push_back('{1, 8'h23, 1, 1, 0, 8'h00, 0, 1, 0});
        vt.push_back('{1, 8'h31, 0, 0, 1, 8'h31, 1, 1, 0});
        vt.push_back('{1, 8'h32, 1, 0, 1, 8'h32, 1, 1, 0});
        vt.push_back('{1, 8'h33, 1, 0, 1, 8'h33, 1, 1, 0});
        vt.push_back('{1, 8'h34, 0, 0, 1, 8'h33, 2, 1, 0});
        vt.push_back('{1, 8'h35, 0, 0, 1, 8'h33, 3, 1, 0});
        vt.push_back('{1, 8'h36, 0, 0, 1, 8'h33, 4, 0, 0});
        vt.push_back('{1, 8'h37, 0, 1, 0, 8'h00, 0, 1, 0});
        vt.push_back('{1, 8'h41, 1, 0, 1, 8'h41, 1, 1, 0});
        vt.push_back('{1, 8'h42, 0, 0, 1, 8'h41, 2, 1, 0});
        vt.push_back('{0, 8'h00, 1, 0, 1, 8'h42, 1, 1, 0});
        vt.push_back('{0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 0});
        vt.push_back('{1, 8'h51, 0, 0, 1, 8'h51, 1, 1, 0});
        vt.push_back('{1, 8'h52, 0, 0, 1, 8'h51, 2, 1, 0});
        vt.push_back('{1, 8'h53, 0, 0, 1, 8'h51, 3, 1, 0});
        vt.push_back('{1, 8'h54, 0, 0, 1, 8'h51, 4, 0, 0});
        vt.push_back('{1, 8'h55, 0, 0, 1, 8'h51, 4, 0, 1});
        vt.push_back('{0, 8'h00, 1, 0, 1, 8'h52, 3, 1, 1});
        vt.push_back('{0, 8'h00, 1, 0, 1, 8'h53, 2, 1, 1});
        vt.push_back('{0, 8'h00, 1, 0, 1, 8'h54, 1, 1, 1});
        vt.push_back('{0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 1});

        #12;
        chk4("reset", 0, 8'h00, 0, 1, 0);
        chk("reset3 valid", 32'(v3), 0);
        chk("reset3 is_empty", 32'(e3), 1);
        chk("reset1 valid", 32'(v1), 0);
        chk("reset1 is_empty", 32'(e1), 1);
        rstn_s = 1'b1;

        foreach (vt[i]) begin
            w4 = vt[i].w; d4 = vt[i].d; r4 = vt[i].r; f4 = vt[i].f;
            step();
            chk4($sformatf("vec%0d", i), vt[i].v, vt[i].q, vt[i].c, vt[i].e, vt[i].o);
        end

        // Async reset mid-stream at count=3 with overflow set.
        r4 = 0; f4 = 0; w4 = 1;
        for (int k = 0; k < 3; k++) begin
            d4 = 8'h60 + 8'(k);
            step();
        end
        w4 = 0;
        chk4("pre_rst", 1, 8'h60, 3, 1, 1);
        #2 rstn_s = 1'b0;
        #1;
        chk4("async_rst", 0, 8'h00, 0, 1, 0);
        #2 rstn_s = 1'b1;
        w4 = 1; d4 = 8'hA5;
        step();
        w4 = 0;
        chk4("post_rst", 1, 8'hA5, 1, 1, 0);

        // DEPTH=3 wrap: continuous push+pop at count=1.
        w3 = 1; d3 = 8'h00;
        step();
        r3 = 1;
        for (int k = 1; k <= 10; k++) begin
            d3 = 8'(k);
            step();
            chk($sformatf("wrap%0d data", k), 32'(q3), 32'(k));
            chk($sformatf("wrap%0d count", k), 32'(c3), 1);
        end
        w3 = 0;
        step();
        chk("wrap drained valid", 32'(v3), 0);
        chk("wrap overflow", 32'(o3), 0);

        // DEPTH=1, WIDTH=1 single-slot handshake.
        w1 = 1; d1 = 1'b1;
        step();
        chk("d1 push valid", 32'(v1), 1);
        chk("d1 push data", 32'(q1), 1);
        chk("d1 push is_empty", 32'(e1), 0);
        chk("d1 push count", 32'(c1), 1);
        d1 = 1'b0;
        step();
        chk("d1 full drop data", 32'(q1), 1);
        chk("d1 full drop ovf", 32'(o1), 1);
        w1 = 0; r1 = 1;
        step();
        chk("d1 pop valid", 32'(v1), 0);
        chk("d1 pop is_empty", 32'(e1), 1);
        w1 = 1; d1 = 1'b1;
        step();
        chk("d1 push+rdy empty valid", 32'(v1), 1);
        d1 = 1'b0;
        step();
        chk("d1 pop+write full valid", 32'(v1), 0);
        chk("d1 pop+write full data", 32'(q1), 0);
        w1 = 0; r1 = 0; f1 = 1;
        step();
        f1 = 0;
        chk("d1 flush ovf", 32'(o1), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
